branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped BTB with a 2-bit BHT for the RV32I pipeline.
- IF stage: predicts the next PC from the fetch PC in the same cycle.
- EX stage: consumes the branch decision result (taken/not-taken) and target, trains the tables, and flags mispredicts for the hazard/flush logic.
- Covers conditional branches only; JAL/JALR are handled elsewhere.

Parameters:
- IDX_BITS, 6, log2 of entry count (64 entries).
- TAG_BITS, 32-IDX_BITS-2, PC tag width (derived; do not override).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  32  fetch PC
- if_pred_taken  out  1  prediction for if_pc
- if_pred_npc  out  32  predicted next PC
- ex_pc  in  32  PC of the instruction in EX
- ex_br_type  in  3  branch type from EX (`NOBRANCH = not a branch)
- ex_br  in  1  actual outcome from the branch decision stage
- ex_target  in  32  computed branch target
- ex_pred_taken  in  1  if_pred_taken carried down the pipeline
- ex_pred_npc  in  32  if_pred_npc carried down the pipeline
- ex_stall  in  1  EX held; suppresses training and mispredict
- ex_mispredict  out  1  flush request
- ex_redirect_pc  out  32  correct next PC when ex_mispredict=1

Behaviour:
Indexing and read path:
- idx = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2].
- Per entry: valid (1), tag, target (32), ctr (2).
- Read is combinational: hit = valid[idx] && tag match.
- if_pred_taken = hit && ctr[1].
- if_pred_npc = if_pred_taken ? target : if_pc+4. Wraps mod 2^32.

Training (ex_upd = ex_br_type != `NOBRANCH && !ex_stall), applied on the clk rising edge:
- Hit, taken: ctr saturating +1 (max 11); target <= ex_target.
- Hit, not taken: ctr saturating -1 (min 00); target unchanged.
- Miss, taken: allocate/overwrite entry: valid=1, tag, target=ex_target, ctr=10.
- Miss, not taken: no change.

Non-branch predicted taken:
- Condition: ex_br_type == `NOBRANCH, ex_pred_taken=1, !ex_stall.
- Clear valid[idx(ex_pc)] at the next edge.

Mispredict (combinational):
- actual_npc = (branch && ex_br) ? ex_target : ex_pc+4.
- ex_mispredict = !ex_stall && (ex_pred_npc != actual_npc).
- ex_redirect_pc = actual_npc.
- Because the comparison is on ex_pred_npc, a correct direction with a stale target is also a mispredict.

Simultaneous read/write to the same index:
- IF sees pre-update contents; no bypass.

Reset:
- Asynchronous assert clears all valid bits and sets all ctr to 01.
- Target/tag arrays are don't-care under reset.
- Outputs during reset: if_pred_taken=0, if_pred_npc=if_pc+4. ex_mispredict follows the combinational equation.
- Reset mid-training: the pending update is discarded.
- Deassertion is synchronised externally; no update occurs on the edge where rst_n rises.

Latency:
- Prediction: 0 cycles.
- Training: visible to IF one cycle after the EX edge.

Optional Feature:
- Macro: BP_PERF_EN.
- Defined: adds two 32-bit counters, both cleared by rst_n and wrapping at 2^32:
  - perf_br_cnt: +1 per ex_upd.
  - perf_miss_cnt: +1 per cycle with ex_mispredict=1.
- Exposed as output ports perf_br_cnt and perf_miss_cnt (32 bits each).
- Not defined: counters and ports are absent; behaviour is otherwise identical.

Decomposition:
- Parameters.v: branch type constants (`NOBRANCH etc., already shared); new `BP_CTR_INIT (2'b01) and `BP_CTR_ALLOC (2'b10).
- Sub-module sat_counter2: 2-bit saturating up/down counter update function/module, instantiated per write path.
- Tables are flat register arrays in the top module.

Test Plan:
- Reset, if_pc=0x100 -> if_pred_taken=0, if_pred_npc=0x104.
- BEQ at ex_pc=0x100, ex_br=1, ex_target=0x80, ex_pred_npc=0x104 -> ex_mispredict=1, redirect=0x80; next cycle if_pc=0x100 gives pred_taken=1, npc=0x80.
- Same branch taken twice more then not-taken once -> ctr 10→11→11→10; prediction stays taken; only the not-taken instance mispredicts, redirect=0x104.
- Aliasing: branch at 0x100 allocated, if_pc=0x200 (same idx for IDX_BITS=6: 0x100 and 0x200 both idx 0, tags differ) -> miss, npc=0x204.
- ex_stall=1 with a taken BNE miss -> no allocation, ex_mispredict=0; drop stall next cycle -> allocation occurs.
- Assert rst_n=0 mid-run after training -> immediately all predictions not-taken; with BP_PERF_EN, both counters read 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: branch type encoding and counter seeds.
package branch_predictor_pkg;

  localparam logic [2:0] NoBranch   = 3'd0;
  localparam logic [1:0] BpCtrInit  = 2'b01;
  localparam logic [1:0] BpCtrAlloc = 2'b10;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter update (pure combinational next value).
module branch_predictor_sat_counter2 (
  input  logic [1:0] ctr_i,
  input  logic       up_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != 2'b11) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != 2'b00) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit BHT: same-cycle prediction in IF, training/mispredict in EX.
// Optional performance counters enabled by defining BP_PERF_EN.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_npc,
  input  logic [31:0] ex_pc,
  input  logic [2:0]  ex_br_type,
  input  logic        ex_br,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_npc,
  input  logic        ex_stall,
  output logic        ex_mispredict,
  output logic [31:0] ex_redirect_pc
`ifdef BP_PERF_EN
  ,
  output logic [31:0] perf_br_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  localparam int unsigned TAG_BITS = 32 - IDX_BITS - 2;
  localparam int unsigned Entries  = 1 << IDX_BITS;

  logic                valid_q  [Entries];
  logic                valid_d  [Entries];
  logic [1:0]          ctr_q    [Entries];
  logic [1:0]          ctr_d    [Entries];
  logic [TAG_BITS-1:0] tag_q    [Entries];
  logic [TAG_BITS-1:0] tag_d    [Entries];
  logic [31:0]         target_q [Entries];
  logic [31:0]         target_d [Entries];

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                if_hit, ex_hit, ex_is_br, ex_upd;
  logic [1:0]          ex_ctr_next;
  logic [31:0]         actual_npc;
  logic                unused_pc_lsbs;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[31:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[31:IDX_BITS+2];
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  // Read path: no bypass, so IF sees table contents from before this cycle's training.
  assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_pred_taken = if_hit && ctr_q[if_idx][1];
  assign if_pred_npc   = if_pred_taken ? target_q[if_idx] : if_pc + 32'd4;

  assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_is_br = ex_br_type != NoBranch;
  assign ex_upd   = ex_is_br && !ex_stall;

  // Comparing full next PCs also catches a correct direction with a stale target.
  assign actual_npc     = (ex_is_br && ex_br) ? ex_target : ex_pc + 32'd4;
  assign ex_mispredict  = !ex_stall && (ex_pred_npc != actual_npc);
  assign ex_redirect_pc = actual_npc;

  branch_predictor_sat_counter2 u_ex_ctr (
    .ctr_i (ctr_q[ex_idx]),
    .up_i  (ex_br),
    .ctr_o (ex_ctr_next)
  );

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (ex_upd) begin
      if (ex_hit) begin
        ctr_d[ex_idx] = ex_ctr_next;
        if (ex_br) target_d[ex_idx] = ex_target;
      end else if (ex_br) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = BpCtrAlloc;
      end
    end else if (!ex_is_br && ex_pred_taken && !ex_stall) begin
      // Something that is not a branch was predicted taken: drop the bogus entry.
      valid_d[ex_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '{default: 1'b0};
      ctr_q   <= '{default: BpCtrInit};
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag/target contents are meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

`ifdef BP_PERF_EN
  logic [31:0] perf_br_cnt_q, perf_br_cnt_d;
  logic [31:0] perf_miss_cnt_q, perf_miss_cnt_d;

  always_comb begin
    perf_br_cnt_d   = perf_br_cnt_q + {31'd0, ex_upd};
    perf_miss_cnt_d = perf_miss_cnt_q + {31'd0, ex_mispredict};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_cnt_q   <= 32'd0;
      perf_miss_cnt_q <= 32'd0;
    end else begin
      perf_br_cnt_q   <= perf_br_cnt_d;
      perf_miss_cnt_q <= perf_miss_cnt_d;
    end
  end

  assign perf_br_cnt   = perf_br_cnt_q;
  assign perf_miss_cnt = perf_miss_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes expectations, a negedge monitor checks.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam logic [2:0] Beq = 3'd1;
  localparam logic [2:0] Bne = 3'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic        if_pred_taken;
  logic [31:0] if_pred_npc;
  logic [31:0] ex_pc = 32'd0;
  logic [2:0]  ex_br_type = NoBranch;
  logic        ex_br = 1'b0;
  logic [31:0] ex_target = 32'd0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_npc = 32'd4;
  logic        ex_stall = 1'b0;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
`ifdef BP_PERF_EN
  logic [31:0] perf_br_cnt, perf_miss_cnt;
`endif

  branch_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_npc    (if_pred_npc),
    .ex_pc          (ex_pc),
    .ex_br_type     (ex_br_type),
    .ex_br          (ex_br),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_npc    (ex_pred_npc),
    .ex_stall       (ex_stall),
    .ex_mispredict  (ex_mispredict),
    .ex_redirect_pc (ex_redirect_pc)
`ifdef BP_PERF_EN
    ,
    .perf_br_cnt    (perf_br_cnt),
    .perf_miss_cnt  (perf_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        taken;
    logic [31:0] npc;
    logic        mis;
    logic [31:0] redir;
    logic        perf_zero;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic cmp(input string nm, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, field, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each issued vector is observed at the next negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      cmp(n, "if_pred_taken", {31'd0, if_pred_taken}, {31'd0, e.taken});
      cmp(n, "if_pred_npc", if_pred_npc, e.npc);
      cmp(n, "ex_mispredict", {31'd0, ex_mispredict}, {31'd0, e.mis});
      cmp(n, "ex_redirect_pc", ex_redirect_pc, e.redir);
`ifdef BP_PERF_EN
      if (e.perf_zero) begin
        cmp(n, "perf_br_cnt", perf_br_cnt, 32'd0);
        cmp(n, "perf_miss_cnt", perf_miss_cnt, 32'd0);
      end
`endif
    end
  end

  task automatic vec(input string nm, input logic [31:0] ipc, input logic [2:0] bt,
                     input logic [31:0] epc, input logic br, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] pnpc, input logic stall,
                     input logic e_tk, input logic [31:0] e_npc, input logic e_mis,
                     input logic [31:0] e_redir, input logic perf_zero = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    if_pc = ipc; ex_br_type = bt; ex_pc = epc; ex_br = br; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_npc = pnpc; ex_stall = stall;
    e.taken = e_tk; e.npc = e_npc; e.mis = e_mis; e.redir = e_redir; e.perf_zero = perf_zero;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // EX idle: not a branch at PC 0 with a consistent prediction, so never a mispredict.
  task automatic idle(input string nm, input logic [31:0] ipc, input logic e_tk,
                      input logic [31:0] e_npc, input logic perf_zero = 1'b0);
    vec(nm, ipc, NoBranch, 32'd0, 1'b0, 32'd0, 1'b0, 32'd4, 1'b0,
        e_tk, e_npc, 1'b0, 32'd4, perf_zero);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle("reset", 32'h100, 1'b0, 32'h104, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Allocation on first taken instance; IF sees pre-update table this cycle.
    vec("alloc", 32'h100, Beq, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0,
        1'b0, 32'h104, 1'b1, 32'h80);
    vec("tk2", 32'h100, Beq, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0,
        1'b1, 32'h80, 1'b0, 32'h80);
    vec("tk3", 32'h100, Beq, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0,
        1'b1, 32'h80, 1'b0, 32'h80);
    vec("nt1", 32'h100, Beq, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0,
        1'b1, 32'h80, 1'b1, 32'h104);
    idle("still_taken", 32'h100, 1'b1, 32'h80);
    idle("alias", 32'h200, 1'b0, 32'h204);

    // Stalled taken miss must neither allocate nor flush.
    vec("stall", 32'h144, Bne, 32'h144, 1'b1, 32'h40, 1'b0, 32'h148, 1'b1,
        1'b0, 32'h148, 1'b0, 32'h40);
    vec("unstall", 32'h144, Bne, 32'h144, 1'b1, 32'h40, 1'b0, 32'h148, 1'b0,
        1'b0, 32'h148, 1'b1, 32'h40);
    idle("after_alloc", 32'h144, 1'b1, 32'h40);

    // Correct direction, stale target.
    vec("stale_tgt", 32'h100, Beq, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80, 1'b0,
        1'b1, 32'h80, 1'b1, 32'h90);
    idle("new_tgt", 32'h100, 1'b1, 32'h90);

    // Non-branch predicted taken invalidates its entry.
    vec("nonbr", 32'h144, NoBranch, 32'h144, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0,
        1'b1, 32'h40, 1'b1, 32'h148);
    idle("nonbr_clr", 32'h144, 1'b0, 32'h148);
    idle("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Walk 11 -> 10 -> 01 -> 00, then check the floor holds (one taken gives 01).
    vec("dn1", 32'h100, Beq, 32'h100, 1'b0, 32'h90, 1'b1, 32'h90, 1'b0,
        1'b1, 32'h90, 1'b1, 32'h104);
    vec("dn2", 32'h100, Beq, 32'h100, 1'b0, 32'h90, 1'b1, 32'h90, 1'b0,
        1'b1, 32'h90, 1'b1, 32'h104);
    vec("dn3", 32'h100, Beq, 32'h100, 1'b0, 32'h90, 1'b0, 32'h104, 1'b0,
        1'b0, 32'h104, 1'b0, 32'h104);
    idle("at_floor", 32'h100, 1'b0, 32'h104);
    vec("up1", 32'h100, Beq, 32'h100, 1'b1, 32'h90, 1'b0, 32'h104, 1'b0,
        1'b0, 32'h104, 1'b1, 32'h90);
    idle("ctr01", 32'h100, 1'b0, 32'h104);
    vec("up2", 32'h100, Beq, 32'h100, 1'b1, 32'h90, 1'b0, 32'h104, 1'b0,
        1'b0, 32'h104, 1'b1, 32'h90);
    idle("ctr10", 32'h100, 1'b1, 32'h90);

    // Mid-run asynchronous reset, with a taken update pending in EX.
    vec("pend", 32'h100, Beq, 32'h100, 1'b1, 32'h90, 1'b1, 32'h90, 1'b0,
        1'b1, 32'h90, 1'b0, 32'h90);
    @(negedge clk);
    #1 rst_n = 1'b0;
    idle("mid_reset", 32'h100, 1'b0, 32'h104, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle("post_reset", 32'h100, 1'b0, 32'h104);
    idle("post_reset144", 32'h144, 1'b0, 32'h148);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
